// File: rtl/vga_pkg.sv
// Shared timing constants, counter type and helper functions for the VGA
// timing generator. Defaults describe 800x600@60.
package vga_pkg;

    localparam int CNT_W   = 11;
    localparam int CNT_LIM = 2048;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    typedef logic [CNT_W-1:0] cnt_t;

    // Registered per-position flags, all describing the same (hcount, vcount).
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblnk;
        logic vblnk;
        logic de;
        logic line_start;
        logic frame_start;
    } vga_flags_t;

    function automatic int h_tot(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_tot(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    // True when lo <= pos < hi.
    function automatic logic in_window(cnt_t pos, cnt_t lo, cnt_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_if.sv
// Bundle of VGA position and sync/blank signals. The generator drives it
// through the out modport; consumers use slave.
interface vga_if;
    import vga_pkg::*;

    cnt_t hcount;
    cnt_t vcount;
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
    // Alias of master under the name the timing generator binds to.
    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_wrap_counter.sv
// Counter 0..MAX-1 with increment enable, wrap indication and synchronous
// reset. Also exposes the value it will hold after the next edge so that
// registered flags can be derived from it without lagging.
module vga_wrap_counter
    import vga_pkg::*;
#(
    parameter int MAX = 1056
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    output cnt_t o_count,
    output cnt_t o_next,
    output logic o_wrap
);

    cnt_t r_count;
    cnt_t w_next;

    assign o_wrap = i_inc && (r_count == cnt_t'(MAX - 1));

    // Next count: reset to zero, otherwise step or wrap when incremented.
    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_count;
        if (rst) begin
            w_next = '0;
        end else if (i_inc) begin
            w_next = o_wrap ? '0 : r_count + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking for state so every register samples pre-edge values.
        r_count <= w_next;
    end

    assign o_count = r_count;
    assign o_next  = w_next;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal/vertical counters with registered sync,
// blank, data-enable and start pulses, all consistent with the counters.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    vga_if.out     out,
    output logic   de,
    output logic   line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic   frame_start,
    output logic [15:0] frame_cnt
`else
    output logic   frame_start
`endif
);

    localparam int H_TOT = h_tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_tot(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam cnt_t H_BLNK_START = cnt_t'(H_ACTIVE);
    localparam cnt_t H_SYNC_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t H_SYNC_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t V_BLNK_START = cnt_t'(V_ACTIVE);
    localparam cnt_t V_SYNC_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t V_SYNC_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOT > CNT_LIM || V_TOT > CNT_LIM) begin : g_bad_total
        $error("vga_timing_gen: H_TOT or V_TOT exceeds 11-bit counter range");
    end
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $error("vga_timing_gen: timing parameters must be non-zero");
    end

    cnt_t       w_h_count, w_h_next, w_v_count, w_v_next;
    logic       w_h_wrap, w_v_wrap;
    vga_flags_t w_next_flags;
    vga_flags_t r_flags;

    vga_wrap_counter #(.MAX(H_TOT)) u_hcnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (en),
        .o_count (w_h_count),
        .o_next  (w_h_next),
        .o_wrap  (w_h_wrap)
    );

    vga_wrap_counter #(.MAX(V_TOT)) u_vcnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_h_wrap),
        .o_count (w_v_count),
        .o_next  (w_v_next),
        .o_wrap  (w_v_wrap)
    );

    // Flags for the position the counters are about to take.
    always_comb begin
        w_next_flags             = '0;
        w_next_flags.hblnk       = (w_h_next >= H_BLNK_START);
        w_next_flags.vblnk       = (w_v_next >= V_BLNK_START);
        w_next_flags.de          = !(w_next_flags.hblnk || w_next_flags.vblnk);
        w_next_flags.hsync       = in_window(w_h_next, H_SYNC_START, H_SYNC_END) ? H_POL : ~H_POL;
        w_next_flags.vsync       = in_window(w_v_next, V_SYNC_START, V_SYNC_END) ? V_POL : ~V_POL;
        w_next_flags.line_start  = (w_h_next == '0);
        w_next_flags.frame_start = (w_h_next == '0) && (w_v_next == '0);
    end

    // Flag register: reset to the (0,0) state, hold while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '{hsync: ~H_POL, vsync: ~V_POL, hblnk: 1'b0, vblnk: 1'b0,
                         de: 1'b1, line_start: 1'b1, frame_start: 1'b1};
        end else if (en) begin
            r_flags <= w_next_flags;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Count every enabled step that lands on (0,0); wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (en && w_next_flags.frame_start) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign out.hcount  = w_h_count;
    assign out.vcount  = w_v_count;
    assign out.hsync   = r_flags.hsync;
    assign out.vsync   = r_flags.vsync;
    assign out.hblnk   = r_flags.hblnk;
    assign out.vblnk   = r_flags.vblnk;
    assign de          = r_flags.de;
    assign line_start  = r_flags.line_start;
    assign frame_start = r_flags.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three instances (default 800x600, 640x480
// with negative sync, and a tiny timing for full-frame coverage) compared
// every cycle against a position-based reference model, plus directed
// boundary checks. Define VGA_TIMING_FRAME_CNT_EN to also cover frame_cnt.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b111;
    logic [2:0] en_v  = 3'b111;

    always #5 clk = ~clk;

    vga_if if_d ();
    vga_if if_v ();
    vga_if if_t ();
    logic de_d, ls_d, fs_d, de_v, ls_v, fs_v, de_t, ls_t, fs_t;
    logic [15:0] fc_d, fc_v, fc_t;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .out(if_d),
        .de(de_d), .line_start(ls_d),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_start(fs_d), .frame_cnt(fc_d)
`else
        .frame_start(fs_d)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33),
        .H_POL(1'b0), .V_POL(1'b0)
    ) u_vga (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .out(if_v),
        .de(de_v), .line_start(ls_v),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_start(fs_v), .frame_cnt(fc_v)
`else
        .frame_start(fs_v)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b1)
    ) u_tiny (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .out(if_t),
        .de(de_t), .line_start(ls_t),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_start(fs_t), .frame_cnt(fc_t)
`else
        .frame_start(fs_t)
`endif
    );

    // Timing table for the reference model, one entry per instance.
    int ha[3] = '{800, 640, 8};
    int hf[3] = '{40, 16, 2};
    int hs[3] = '{128, 96, 3};
    int hb[3] = '{88, 48, 2};
    int va[3] = '{600, 480, 4};
    int vf[3] = '{1, 10, 1};
    int vs[3] = '{4, 2, 2};
    int vb[3] = '{23, 33, 1};
    bit hp[3] = '{1'b1, 1'b0, 1'b0};
    bit vp[3] = '{1'b1, 1'b0, 1'b1};

    int mh[3], mv[3], mfc[3];
    int errors = 0;
    int checks = 0;

    int lo_cnt = 0, lo_min = 99999, lo_max = -1;
    int vs_min = 99999, vs_max = -1;
    int fs_cnt_t = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs purely from the current model position and the timing rules.
    function automatic logic [31:0] exp_vec(int k);
        int h = mh[k];
        int v = mv[k];
        logic [10:0] h11 = h[10:0];
        logic [10:0] v11 = v[10:0];
        logic hbl = (h >= ha[k]);
        logic vbl = (v >= va[k]);
        logic hsa = (h >= ha[k] + hf[k]) && (h < ha[k] + hf[k] + hs[k]);
        logic vsa = (v >= va[k] + vf[k]) && (v < va[k] + vf[k] + vs[k]);
        logic hsy = hsa ? hp[k] : !hp[k];
        logic vsy = vsa ? vp[k] : !vp[k];
        return {3'b000, h11, v11, hsy, vsy, hbl, vbl, !(hbl || vbl), h == 0, (h == 0) && (v == 0)};
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst_v[k]) begin
                mh[k] = 0;
                mv[k] = 0;
                mfc[k] = 0;
            end else if (en_v[k]) begin
                mh[k]++;
                if (mh[k] == ha[k] + hf[k] + hs[k] + hb[k]) begin
                    mh[k] = 0;
                    mv[k]++;
                    if (mv[k] == va[k] + vf[k] + vs[k] + vb[k]) mv[k] = 0;
                end
                if (mh[k] == 0 && mv[k] == 0) mfc[k] = (mfc[k] + 1) % 65536;
            end
        end
        #1;
        check("def_out", {3'b000, if_d.hcount, if_d.vcount, if_d.hsync, if_d.vsync,
                          if_d.hblnk, if_d.vblnk, de_d, ls_d, fs_d}, exp_vec(0));
        check("vga_out", {3'b000, if_v.hcount, if_v.vcount, if_v.hsync, if_v.vsync,
                          if_v.hblnk, if_v.vblnk, de_v, ls_v, fs_v}, exp_vec(1));
        check("tiny_out", {3'b000, if_t.hcount, if_t.vcount, if_t.hsync, if_t.vsync,
                           if_t.hblnk, if_t.vblnk, de_t, ls_t, fs_t}, exp_vec(2));
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("def_fcnt", {16'd0, fc_d}, mfc[0]);
        check("vga_fcnt", {16'd0, fc_v}, mfc[1]);
        check("tiny_fcnt", {16'd0, fc_t}, mfc[2]);
`endif
        if (if_v.hsync === 1'b0) begin
            lo_cnt++;
            if (int'(if_v.hcount) < lo_min) lo_min = int'(if_v.hcount);
            if (int'(if_v.hcount) > lo_max) lo_max = int'(if_v.hcount);
        end
        if (if_t.vsync === 1'b1) begin
            if (int'(if_t.vcount) < vs_min) vs_min = int'(if_t.vcount);
            if (int'(if_t.vcount) > vs_max) vs_max = int'(if_t.vcount);
        end
        if (fs_t === 1'b1) fs_cnt_t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Walk the tiny instance to a model position within a bounded number of cycles.
    task automatic goto_tiny(input int h, input int v);
        int n = 0;
        while (!(mh[2] == h && mv[2] == v) && n < 500) begin
            step();
            n++;
        end
        check("goto_tiny_bound", {31'd0, n < 500}, 32'd1);
    endtask

    initial begin
        // Reset all instances together.
        step();
        check("rst_def_h", if_d.hcount, 0);
        check("rst_def_v", if_d.vcount, 0);
        check("rst_def_flags", {if_d.hsync, if_d.vsync, if_d.hblnk, if_d.vblnk, de_d, ls_d, fs_d},
              7'b0000111);
        check("rst_vga_sync", {if_v.hsync, if_v.vsync}, 2'b11);
        rst_v = 3'b000;
        fs_cnt_t = 0;

        // Three tiny frames from reset.
        run(360);
        check("tiny_fs_3frames", fs_cnt_t, 3);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("tiny_fcnt_3", {16'd0, fc_t}, 3);
`endif

        // 640x480 line length 800; default reaches first blanking pixel.
        run(440);
        check("vga_htot_h", if_v.hcount, 0);
        check("vga_htot_v", if_v.vcount, 1);
        check("def_h800", if_d.hcount, 800);
        check("def_h800_blank", {if_d.hblnk, de_d}, 2'b10);

        // Default completes its first line.
        run(256);
        check("def_line_h", if_d.hcount, 0);
        check("def_line_v", if_d.vcount, 1);
        check("def_line_ls", ls_d, 1);
        check("vga_hsync_low_cnt", lo_cnt, 96);

        // Freeze the default instance mid-line.
        run(100);
        en_v[0] = 1'b0;
        run(10);
        check("def_freeze_h", if_d.hcount, 100);
        check("def_freeze_v", if_d.vcount, 1);
        en_v[0] = 1'b1;
        step();
        check("def_resume_h", if_d.hcount, 101);

        // Reset mid-line on the default instance.
        run(399);
        check("def_h500", if_d.hcount, 500);
        rst_v[0] = 1'b1;
        step();
        rst_v[0] = 1'b0;
        check("def_midrst_pos", {if_d.hcount, if_d.vcount}, 22'd0);
        check("def_midrst_flags", {if_d.hsync, if_d.vsync, if_d.hblnk, if_d.vblnk}, 4'b0000);

        // Hold the tiny instance on its wrap cycle.
        goto_tiny(14, 7);
        en_v[2] = 1'b0;
        run(10);
        check("tiny_hold_pos", {if_t.hcount, if_t.vcount}, {11'd14, 11'd7});
        check("tiny_hold_flags", {if_t.hblnk, if_t.vblnk, de_t, fs_t}, 4'b1100);
        en_v[2] = 1'b1;
        step();
        check("tiny_wrap_pos", {if_t.hcount, if_t.vcount}, 22'd0);
        check("tiny_wrap_fs", {ls_t, fs_t}, 2'b11);

        // Reset mid-frame on the tiny instance.
        goto_tiny(5, 3);
        rst_v[2] = 1'b1;
        step();
        rst_v[2] = 1'b0;
        check("tiny_midrst_pos", {if_t.hcount, if_t.vcount}, 22'd0);
        check("tiny_midrst_sync", {if_t.hsync, if_t.vsync}, 2'b10);

        // Randomized enable and occasional reset on every instance.
        for (int i = 0; i < 6000; i++) begin
            for (int k = 0; k < 3; k++) begin
                en_v[k]  = ($urandom_range(0, 9) != 0);
                rst_v[k] = ($urandom_range(0, 499) == 0);
            end
            step();
        end
        rst_v = 3'b000;
        en_v  = 3'b111;
        run(20);

        check("vga_hsync_lo_min", lo_min, 656);
        check("vga_hsync_lo_max", lo_max, 751);
        check("tiny_vsync_min", vs_min, 5);
        check("tiny_vsync_max", vs_max, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
